// File: rtl/round_arb_mux.sv
// N-channel byte-stream arbiter/mux feeding SubBytes.
// Arbitration is locked per block; output is a single register.
module round_arb_mux #(
  parameter int DATA_W      = 8,
  parameter int NUM_CH      = 2,
  parameter int BLOCK_BYTES = 16,
  parameter int ARB_MODE    = 0,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  output logic                     dout_last,
  output logic [CH_W-1:0]          dout_ch,
  input  logic                     dout_ready
);

  localparam int CNT_W = $clog2(BLOCK_BYTES) + 1;

  if (NUM_CH < 2 || NUM_CH > 16 || BLOCK_BYTES < 1) begin : g_param_chk
    $error("round_arb_mux: illegal NUM_CH or BLOCK_BYTES");
  end

  typedef enum logic {IDLE, LOCK} state_t;

  state_t            state, state_n;
  logic [CH_W-1:0]   owner, owner_n;
  logic [CH_W-1:0]   rr_ptr, rr_n;
  logic [CH_W-1:0]   win, acc_ch;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              found;
  logic              load_ok;
  logic              acc;
  logic              last_n;
  logic [NUM_CH-1:0] grant;

  function automatic logic [CH_W-1:0] next_ch(
    input logic [CH_W-1:0] c
  );
    if (int'(c) == NUM_CH - 1) return '0;
    return c + CH_W'(1);
  endfunction

  always_comb begin
    win   = '0;
    found = 1'b0;
    if (ARB_MODE == 0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (in_valid[i]) begin
          win   = CH_W'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!found &&
            in_valid[(int'(rr_ptr) + k) % NUM_CH]) begin
          win   = CH_W'((int'(rr_ptr) + k) % NUM_CH);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (state == IDLE) begin
      if (found) grant[win] = 1'b1;
    end else begin
      grant[owner] = 1'b1;
    end
  end

  assign load_ok  = !dout_valid || dout_ready;
  assign in_ready = (rst || !load_ok) ? '0 : grant;
  assign acc      = |(in_valid & in_ready);
  assign acc_ch   = (state == IDLE) ? win : owner;

  always_comb begin
    state_n = state;
    owner_n = owner;
    cnt_n   = cnt;
    rr_n    = rr_ptr;
    last_n  = 1'b0;
    if (acc) begin
      unique case (state)
        IDLE: begin
          if (BLOCK_BYTES == 1) begin
            last_n = 1'b1;
            rr_n   = next_ch(win);
          end else begin
            owner_n = win;
            cnt_n   = CNT_W'(1);
            state_n = LOCK;
          end
        end
        LOCK: begin
          if (cnt == CNT_W'(BLOCK_BYTES - 1)) begin
            last_n  = 1'b1;
            cnt_n   = '0;
            state_n = IDLE;
            rr_n    = next_ch(owner);
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      cnt        <= '0;
      rr_ptr     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      dout_ch    <= '0;
    end else begin
      state  <= state_n;
      owner  <= owner_n;
      cnt    <= cnt_n;
      rr_ptr <= rr_n;
      if (acc) begin
        dout       <= in_data[acc_ch*DATA_W +: DATA_W];
        dout_valid <= 1'b1;
        dout_last  <= last_n;
        dout_ch    <= acc_ch;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_round_arb_mux.sv
// Bench for round_arb_mux: default instance plus a 4-channel
// round-robin instance, checked against an expected-byte scoreboard.
module tb_round_arb_mux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  v0, rdy0;
  logic [15:0] dat0;
  logic [7:0]  dout0;
  logic        dv0, dl0, dr0;
  logic [0:0]  dch0;

  logic [3:0]  v1, rdy1;
  logic [31:0] dat1;
  logic [7:0]  dout1;
  logic        dv1, dl1, dr1;
  logic [1:0]  dch1;

  round_arb_mux u_d0 (
    .clk(clk), .rst(rst),
    .in_valid(v0), .in_data(dat0), .in_ready(rdy0),
    .dout(dout0), .dout_valid(dv0), .dout_last(dl0),
    .dout_ch(dch0), .dout_ready(dr0)
  );

  round_arb_mux #(
    .NUM_CH(4), .BLOCK_BYTES(4), .ARB_MODE(1)
  ) u_d1 (
    .clk(clk), .rst(rst),
    .in_valid(v1), .in_data(dat1), .in_ready(rdy1),
    .dout(dout1), .dout_valid(dv1), .dout_last(dl1),
    .dout_ch(dch1), .dout_ready(dr1)
  );

  typedef struct {
    logic [7:0] d;
    logic [1:0] ch;
    logic       last;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       dr;
    logic [1:0] rdy;
    logic       dv;
    logic [7:0] d;
    logic       last;
    logic       ch;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int first1 = -1;
  int last1 = -1;

  logic [1:0] en0, acc0;
  logic [3:0] en1, acc1;
  int sent0[2], quota0[2], base0[2];
  int sent1[4], quota1[4];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push0(input int d, input int ch, input bit l);
    exp_t e;
    e.d = 8'(d); e.ch = 2'(ch); e.last = l;
    q0.push_back(e);
  endtask

  task automatic push1(input int d, input int ch, input bit l);
    exp_t e;
    e.d = 8'(d); e.ch = 2'(ch); e.last = l;
    q1.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      v0[i] = en0[i] && (sent0[i] < quota0[i]);
      dat0[i*8 +: 8] = 8'(base0[i] + sent0[i]);
    end
    for (int i = 0; i < 4; i++) begin
      v1[i] = en1[i] && (sent1[i] < quota1[i]);
      dat1[i*8 +: 8] = 8'(i * 64 + sent1[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (acc0[i]) sent0[i]++;
    for (int i = 0; i < 4; i++) if (acc1[i]) sent1[i]++;
    drive();
  endtask

  always @(negedge clk) begin
    cyc++;
    acc0 = v0 & rdy0;
    acc1 = v1 & rdy1;
    if (dv0 && dr0) begin
      if (q0.size() == 0) begin
        n_total++;
        $display("FAIL d0_extra: got %h, none expected", dout0);
      end else begin
        e0 = q0.pop_front();
        chk("d0_byte", 32'(dout0), 32'(e0.d));
        chk("d0_ch", 32'(dch0), 32'(e0.ch));
        chk("d0_last", 32'(dl0), 32'(e0.last));
      end
    end
    if (dv1 && dr1) begin
      if (first1 < 0) first1 = cyc;
      last1 = cyc;
      if (q1.size() == 0) begin
        n_total++;
        $display("FAIL d1_extra: got %h, none expected", dout1);
      end else begin
        e1 = q1.pop_front();
        chk("d1_byte", 32'(dout1), 32'(e1.d));
        chk("d1_ch", 32'(dch1), 32'(e1.ch));
        chk("d1_last", 32'(dl1), 32'(e1.last));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[5];
    int stall, gc, rc;
    bit stalled, rdone;

    tab[0] = '{1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
    tab[1] = '{1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
    tab[2] = '{1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0};
    tab[3] = '{1'b0, 1'b1, 2'b10, 1'b1, 8'hA0, 1'b0, 1'b1};
    tab[4] = '{1'b0, 1'b1, 2'b10, 1'b1, 8'hA1, 1'b0, 1'b1};

    rst = 1'b1;
    dr0 = 1'b1;
    dr1 = 1'b1;
    base0[0] = 8'h10;
    base0[1] = 8'hA0;
    for (int i = 0; i < 2; i++) begin
      sent0[i] = 0; quota0[i] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      sent1[i] = 0; quota1[i] = 0;
    end
    en0 = 2'b00;
    en1 = 4'b0000;
    acc0 = '0;
    acc1 = '0;
    drive();

    // reset, then fixed priority: ch1 wins two blocks, ch0 after
    en0 = 2'b11;
    quota0[0] = 16;
    quota0[1] = 32;
    for (int k = 0; k < 32; k++)
      push0(8'hA0 + k, 1, (k % 16) == 15);
    for (int k = 0; k < 16; k++)
      push0(8'h10 + k, 0, k == 15);
    drive();
    for (int r = 0; r < 5; r++) begin
      tick();
      rst = tab[r].rst;
      dr0 = tab[r].dr;
      drive();
      @(negedge clk);
      chk("vec_rdy", 32'(rdy0), 32'(tab[r].rdy));
      chk("vec_dv", 32'(dv0), 32'(tab[r].dv));
      chk("vec_dout", 32'(dout0), 32'(tab[r].d));
      chk("vec_last", 32'(dl0), 32'(tab[r].last));
      chk("vec_ch", 32'(dch0), 32'(tab[r].ch));
    end
    for (int c = 0; c < 200 &&
         !(q0.size() == 0 && sent0[0] == 16 &&
           sent0[1] == 32); c++) begin
      tick();
      @(negedge clk);
    end
    chk("prio_done", 32'(q0.size()), 0);

    // round-robin instance, all four channels valid
    en1 = 4'hF;
    for (int i = 0; i < 4; i++) quota1[i] = 8;
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < 4; k++)
        push1((b % 4) * 64 + (b / 4) * 4 + k, b % 4, k == 3);
    drive();
    for (int c = 0; c < 200 && q1.size() != 0; c++) begin
      tick();
      @(negedge clk);
    end
    chk("rr_done", 32'(q1.size()), 0);
    chk("rr_span", 32'(last1 - first1 + 1), 32);

    // backpressure while 0xA4 is held
    for (int i = 0; i < 2; i++) begin
      sent0[i] = 0; quota0[i] = 0;
    end
    quota0[1] = 16;
    for (int k = 0; k < 16; k++)
      push0(8'hA0 + k, 1, k == 15);
    stall = 0;
    stalled = 0;
    for (int c = 0; c < 200 &&
         !(q0.size() == 0 && sent0[1] == 16); c++) begin
      tick();
      if (stall > 0) stall--;
      if (stall == 0 && !stalled && dv0 &&
          dout0 == 8'hA4) begin
        stall = 3;
        stalled = 1;
      end
      dr0 = (stall == 0);
      @(negedge clk);
      if (stall > 0) begin
        chk("bp_hold", 32'(dout0), 32'hA4);
        chk("bp_valid", 32'(dv0), 1);
        chk("bp_rdy", 32'(rdy0), 0);
      end
    end
    dr0 = 1'b1;
    chk("bp_stalled", 32'(stalled), 1);
    chk("bp_done", 32'(q0.size()), 0);

    // owner gap: ch1 drops valid for three cycles mid-block
    for (int i = 0; i < 2; i++) begin
      sent0[i] = 0; quota0[i] = 16;
    end
    for (int k = 0; k < 16; k++)
      push0(8'hA0 + k, 1, k == 15);
    for (int k = 0; k < 16; k++)
      push0(8'h10 + k, 0, k == 15);
    gc = 0;
    for (int c = 0; c < 200 &&
         !(q0.size() == 0 && sent0[0] == 16); c++) begin
      tick();
      if (gc > 0) gc++;
      if (gc == 0 && sent0[1] == 5) gc = 1;
      en0[1] = !(gc >= 1 && gc <= 3);
      drive();
      @(negedge clk);
      if (gc >= 1 && gc <= 3)
        chk("gap_ch0_rdy", 32'(rdy0[0]), 0);
      if (gc >= 2 && gc <= 4)
        chk("gap_bubble", 32'(dv0), 0);
    end
    en0 = 2'b11;
    chk("gap_done", 32'(q0.size()), 0);

    // reset pulse after seven bytes of a ch0 block
    for (int i = 0; i < 2; i++) begin
      sent0[i] = 0; quota0[i] = 0;
    end
    quota0[0] = 23;
    for (int k = 0; k < 7; k++)
      push0(8'h10 + k, 0, 1'b0);
    for (int k = 0; k < 16; k++)
      push0(8'h17 + k, 0, k == 15);
    rdone = 0;
    rc = 0;
    for (int c = 0; c < 200 &&
         !(q0.size() == 0 && sent0[0] == 23); c++) begin
      tick();
      rst = 1'b0;
      if (rc > 0) rc++;
      if (!rdone && sent0[0] == 7) begin
        rst = 1'b1;
        rdone = 1;
        rc = 1;
      end
      drive();
      @(negedge clk);
      if (rc == 1) chk("rst_rdy", 32'(rdy0), 0);
      if (rc == 2) begin
        chk("rst_dv", 32'(dv0), 0);
        chk("rst_dout", 32'(dout0), 0);
        chk("rst_last", 32'(dl0), 0);
        chk("rst_ch", 32'(dch0), 0);
      end
    end
    rst = 1'b0;
    chk("rst_done", 32'(q0.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
